// File: rtl/fanin_pkg.sv
// Shared widths, defaults and FIFO entry layout
// for the fan-in merge buffer.
package fanin_pkg;

  localparam int N_IN_DEF  = 4;
  localparam int W_DEF     = 8;
  localparam int DEPTH_DEF = 4;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [clog2_min1(N_IN_DEF)-1:0] src;
    logic [W_DEF-1:0]                data;
  } entry_t;

endpackage

// File: rtl/fanin_merge_buffer_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first
// requester at or after rr_ptr.
module rr_arbiter
  import fanin_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             req,
  input  logic                     advance,
  output logic [N-1:0]             grant,
  output logic [clog2_min1(N)-1:0] grant_idx
);

  localparam int IW = clog2_min1(N);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] idx;
  logic          found;
  int            j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N) j = j - N;
      idx = IW'(j);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (int'(grant_idx) == N - 1) ? '0
              : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/fanin_merge_buffer.sv
// N-to-1 valid/ready merge into a tagged FIFO,
// fed by a round-robin arbiter.
module fanin_merge_buffer
  import fanin_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_IN-1:0]             in_valid,
  input  logic [N_IN*W-1:0]           in_data,
  output logic [N_IN-1:0]             in_ready,
  output logic                        out_valid,
  output logic [W-1:0]                out_data,
  output logic [clog2_min1(N_IN)-1:0] out_src,
  input  logic                        out_ready,
  output logic [$clog2(DEPTH+1)-1:0]  fill
);

  localparam int SRC_W = clog2_min1(N_IN);
  localparam int AW    = clog2_min1(DEPTH);
  localparam int FW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [SRC_W-1:0] src;
    logic [W-1:0]     data;
  } slot_t;

  slot_t            mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [N_IN-1:0]  grant;
  logic [SRC_W-1:0] grant_idx;
  logic             accept;
  logic             pop;

  // A full FIFO refuses input even when the head pops this cycle.
  assign accept = !rst && (fill < FW'(DEPTH)) && (|in_valid);
  assign pop    = out_valid && out_ready;

  rr_arbiter #(.N(N_IN)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign in_ready  = accept ? grant : '0;
  assign out_valid = (fill != '0);
  assign out_data  = mem[rd_ptr].data;
  assign out_src   = mem[rd_ptr].src;

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= '{
        src:  grant_idx,
        data: in_data[int'(grant_idx)*W +: W]
      };
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      unique case ({accept, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

endmodule
